// File: rtl/edge_delay_pkg.sv
// Shared types and default sizing for the edge_delay_timer slice.
// Holds the FSM state encoding and the default counter/synchroniser widths.
package edge_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } edge_delay_state_t;

    localparam int EDGE_DELAY_CNT_W       = 8;
    localparam int EDGE_DELAY_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser built from sync-reset d_ff-style stages.
// Stage 0 captures the raw input; q is the last stage.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic res,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_s;

    always_ff @(posedge CLK) begin
        if (res) begin
            r_s <= '0;
        end else begin
            r_s <= {r_s[STAGES-2:0], d};
        end
    end

    assign q = r_s[STAGES-1];

endmodule

// File: rtl/edge_delay_timer.sv
// Synchronises D, detects rising edges and emits a one-cycle Q pulse `delay` cycles later.
// Define EDGE_DELAY_RETRIGGER_EN to let edges while busy restart timing instead of setting overrun.
import edge_delay_pkg::*;

module edge_delay_timer #(
    parameter int CNT_W       = EDGE_DELAY_CNT_W,
    parameter int SYNC_STAGES = EDGE_DELAY_SYNC_STAGES
) (
    input  logic             CLK,
    input  logic             res,
    input  logic             D,
    input  logic [CNT_W-1:0] delay,
    output logic             Q,
    output logic             busy,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] L_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              w_sync;
    logic              r_prev;
    logic              w_edge;
    logic              w_delayZero;
    edge_delay_state_t r_state;
    edge_delay_state_t w_stateNext;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cntNext;
`ifndef EDGE_DELAY_RETRIGGER_EN
    logic              r_overrun;
    logic              w_overrunSet;
`endif

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .CLK (CLK),
        .res (res),
        .d   (D),
        .q   (w_sync)
    );

    assign w_edge      = w_sync & ~r_prev;
    assign w_delayZero = (delay == '0);

    always_ff @(posedge CLK) begin
        if (res) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_prev  <= w_sync;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
`ifndef EDGE_DELAY_RETRIGGER_EN
        w_overrunSet = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    if (w_delayZero) begin
                        w_stateNext = FIRE;
                    end else begin
                        w_stateNext = COUNT;
                        w_cntNext   = delay;
                    end
                end
            end
            COUNT: begin
                // Stop at 1 rather than decrementing further, so cnt never underflows.
                if (r_cnt == L_CNT_ONE) begin
                    w_stateNext = FIRE;
                end else begin
                    w_cntNext = r_cnt - L_CNT_ONE;
                end
`ifdef EDGE_DELAY_RETRIGGER_EN
                if (w_edge) begin
                    if (w_delayZero) begin
                        w_stateNext = FIRE;
                    end else begin
                        w_stateNext = COUNT;
                        w_cntNext   = delay;
                    end
                end
`else
                w_overrunSet = w_edge;
`endif
            end
            FIRE: begin
                w_stateNext = IDLE;
`ifdef EDGE_DELAY_RETRIGGER_EN
                if (w_edge) begin
                    if (w_delayZero) begin
                        w_stateNext = FIRE;
                    end else begin
                        w_stateNext = COUNT;
                        w_cntNext   = delay;
                    end
                end
`else
                w_overrunSet = w_edge;
`endif
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

`ifdef EDGE_DELAY_RETRIGGER_EN
    assign overrun = 1'b0;
`else
    // Sticky drop flag; only reset clears it.
    always_ff @(posedge CLK) begin
        if (res) begin
            r_overrun <= 1'b0;
        end else if (w_overrunSet) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

    assign Q    = (r_state == FIRE);
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_edge_delay_timer.sv
// Directed scoreboard bench for edge_delay_timer: expected Q pulse cycles are queued at stimulus time.
// Honours EDGE_DELAY_RETRIGGER_EN for the busy-edge scenario.
`timescale 1ps/1ps

module tb_edge_delay_timer;

    logic       CLK = 1'b0;
    logic       res;
    logic       D;
    logic [7:0] delay;
    logic       Q;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int cycleCount = 0;
    int pulseCount = 0;
    int expQ[$];

    edge_delay_timer #(
        .CNT_W       (8),
        .SYNC_STAGES (2)
    ) dut (
        .CLK     (CLK),
        .res     (res),
        .D       (D),
        .delay   (delay),
        .Q       (Q),
        .busy    (busy),
        .overrun (overrun)
    );

    always #50 CLK = ~CLK;

    always @(posedge CLK) cycleCount++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic d, input logic [7:0] dly);
        D     = d;
        delay = dly;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Every Q pulse must match the oldest queued expected cycle.
    always @(negedge CLK) begin
        if (Q === 1'b1) begin
            pulseCount++;
            if (expQ.size() == 0) begin
                checkOutput("q_unexpected_pulse", cycleCount, 32'hFFFF_FFFF);
            end else begin
                checkOutput("q_pulse_cycle", cycleCount, expQ.pop_front());
            end
        end
    end

    initial begin
        int k;
        int pBefore;

        res = 1'b1;
        applyStimulus(1'b1, 8'd0);
        stepCycles(2);
        checkOutput("rst_q", Q, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);

        // Release with D already high: p0 is the first posedge after release.
        res = 1'b0;
        k = cycleCount;
        expQ.push_back(k + 3);
        stepCycles(3);
        checkOutput("t1_busy_fire", busy, 1'b1);
        stepCycles(1);
        checkOutput("t1_busy_after", busy, 1'b0);

        $display("[TB] delay=0 single rise");
        applyStimulus(1'b0, 8'd0);
        stepCycles(3);
        k = cycleCount;
        applyStimulus(1'b1, 8'd0);
        expQ.push_back(k + 3);
        stepCycles(2);
        checkOutput("t2_busy_pre", busy, 1'b0);
        stepCycles(1);
        checkOutput("t2_busy_fire", busy, 1'b1);
        checkOutput("t2_q_fire", Q, 1'b1);
        stepCycles(1);
        checkOutput("t2_busy_post", busy, 1'b0);
        checkOutput("t2_q_post", Q, 1'b0);

        $display("[TB] delay=5, delay changed mid-count");
        applyStimulus(1'b0, 8'd0);
        stepCycles(3);
        k = cycleCount;
        applyStimulus(1'b1, 8'd5);
        expQ.push_back(k + 8);
        for (int i = 1; i <= 9; i++) begin
            stepCycles(1);
            if (i == 4) delay = 8'd1;
            checkOutput($sformatf("t3_busy_c%0d", i), busy, (i >= 3 && i <= 8));
        end
        applyStimulus(1'b0, 8'd1);
        stepCycles(3);

        $display("[TB] delay=4, second rise during COUNT");
        k = cycleCount;
        applyStimulus(1'b1, 8'd4);
`ifdef EDGE_DELAY_RETRIGGER_EN
        expQ.push_back(k + 10);
`else
        expQ.push_back(k + 7);
`endif
        stepCycles(1);
        D = 1'b0;
        stepCycles(2);
        D = 1'b1;
        stepCycles(4);
`ifdef EDGE_DELAY_RETRIGGER_EN
        checkOutput("t4_overrun", overrun, 1'b0);
`else
        checkOutput("t4_overrun", overrun, 1'b1);
`endif
        stepCycles(6);
        D = 1'b0;
`ifdef EDGE_DELAY_RETRIGGER_EN
        checkOutput("t4_overrun_late", overrun, 1'b0);
`else
        checkOutput("t4_overrun_sticky", overrun, 1'b1);
`endif
        checkOutput("t4_busy_idle", busy, 1'b0);
        stepCycles(3);

        $display("[TB] delay=10, reset during COUNT");
        pBefore = pulseCount;
        k = cycleCount;
        applyStimulus(1'b1, 8'd10);
        stepCycles(5);
        checkOutput("t5_busy_counting", busy, 1'b1);
        res = 1'b1;
        D = 1'b0;
        stepCycles(1);
        checkOutput("t5_busy_reset", busy, 1'b0);
        checkOutput("t5_q_reset", Q, 1'b0);
        checkOutput("t5_overrun_reset", overrun, 1'b0);
        res = 1'b0;
        stepCycles(20);
        checkOutput("t5_no_pulse", pulseCount, pBefore);

        $display("[TB] delay=255, D held high");
        pBefore = pulseCount;
        k = cycleCount;
        applyStimulus(1'b1, 8'd255);
        expQ.push_back(k + 258);
        stepCycles(300);
        D = 1'b0;
        stepCycles(5);
        checkOutput("t6_one_pulse", pulseCount, pBefore + 1);
        checkOutput("t6_busy_end", busy, 1'b0);

        checkOutput("missing_pulses", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
